branch_predictor_bht: RTL and testbench
=======================================

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL provide parameter INDEX_BITS, default 6; table holds 2^INDEX_BITS entries.
REQ-002 SHALL provide parameter COUNTER_INIT, default 2'b01 (weakly not-taken); reset value of every table entry.
REQ-003 SHALL use one clock and a reset that is asynchronous and active-high, named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 PCNow_ID  input  32  PC of the instruction in ID (lookup address).
REQ-007 IsBranch_ID  input  1  ID instruction is a conditional branch.
REQ-008 Prediction  output  1  taken prediction for the ID instruction; carried to EX through the ID/EX register.
REQ-009 Resolve_EX  input  1  a conditional branch in EX resolves this cycle.
REQ-010 Squash_EX  input  1  the EX instruction is flushed; its resolution is discarded.
REQ-011 PCNow_EX  input  32  PC of the resolving branch.
REQ-012 Taken_EX  input  1  actual branch outcome.
REQ-013 Prediction_EX  input  1  prediction carried with the resolving branch.
REQ-014 Mispredict  output  1  redirect/flush request for IF and ID.
REQ-015 BranchCount  output  32  number of valid resolutions since reset.
REQ-016 MispredictCount  output  32  number of valid mispredictions since reset.

Function
REQ-017 Lookup index SHALL be PCNow_ID[INDEX_BITS+1:2]; update index SHALL be PCNow_EX[INDEX_BITS+1:2]; PC bits [1:0] are ignored.
REQ-018 Each entry SHALL be a 2-bit saturating counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-019 Prediction SHALL be combinational: entry[index][1] AND IsBranch_ID; 0 when IsBranch_ID=0.
REQ-020 A valid resolution SHALL be Resolve_EX=1 AND Squash_EX=0.
REQ-021 On a valid resolution, the entry SHALL update at the next rising clk: Taken_EX=1 increments, Taken_EX=0 decrements.
REQ-022 Updates SHALL saturate: 11 with Taken_EX=1 stays 11; 00 with Taken_EX=0 stays 00.
REQ-023 Mispredict SHALL be combinational: valid resolution AND (Taken_EX != Prediction_EX).
REQ-024 Same-cycle lookup and update of one index SHALL return the pre-update value; there is no bypass.
REQ-025 BranchCount SHALL increment by 1 per valid resolution and saturate at 32'hFFFFFFFF.
REQ-026 MispredictCount SHALL increment when Mispredict=1 and saturate at 32'hFFFFFFFF.
REQ-027 Only one entry SHALL change per cycle; all other entries hold.
REQ-028 Lookup latency SHALL be 0 cycles; update latency SHALL be 1 cycle.

Reset
REQ-029 rst=1 SHALL immediately set all entries to COUNTER_INIT and both statistics counters to 0, independent of clk.
REQ-030 While rst=1, Resolve_EX SHALL cause no state change.
REQ-031 While rst=1, Prediction SHALL reflect COUNTER_INIT[1] AND IsBranch_ID.
REQ-032 While rst=1, Mispredict SHALL be 0.
REQ-033 Deasserting rst in mid-sequence SHALL lose all prior history; the first valid update applies from COUNTER_INIT.

Structure
REQ-034 The counter-state encodings (SNT/WNT/WT/ST) and the default INDEX_BITS SHALL reside in shared package bp_pkg.
REQ-035 The 2-bit saturating next-state logic SHALL be a sub-module, bht_counter_update (inputs: state, taken; output: next state), instantiated once on the update path.
REQ-036 The table SHALL be flip-flops, not inferred RAM, so asynchronous reset clears every entry.

Verification
REQ-037 Reset, then PCNow_ID=0x00000040, IsBranch_ID=1 -> Prediction=0 (init 01); IsBranch_ID=0 -> Prediction=0.
REQ-038 Two valid resolutions at PCNow_EX=0x40 with Taken_EX=1 -> entry 16 goes 01->10->11; lookup 0x40 gives Prediction=1; a third taken keeps 11.
REQ-039 Resolve at 0x40 with Taken_EX=0 and Prediction_EX=1 -> Mispredict=1 that cycle; MispredictCount=1; BranchCount=1; entry decrements.
REQ-040 Resolve_EX=1 with Squash_EX=1 and Taken_EX!=Prediction_EX -> Mispredict=0; no entry change; counts unchanged.
REQ-041 Same-cycle lookup and update at index 16 (entry 01, Taken_EX=1) -> Prediction=0 that cycle and 1 the next cycle. Aliasing case: PC 0x40 and 0x140 share index 16 when INDEX_BITS=6.
REQ-042 Assert rst asynchronously between clk edges after training -> entries return to 01 and counts to 0 before the next edge; a Resolve_EX pulse during rst has no effect.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings and default table size for the branch history table
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  localparam int BP_INDEX_BITS = 6;
endpackage

// File: rtl/bht_counter_update.sv
// bht_counter_update: 2-bit saturating counter next-state logic
module bht_counter_update
  import bp_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] next_state_o
);
  always_comb
    next_state_o = taken_i ? ((state_i == ST) ? state_i : state_i + 2'd1)
                           : ((state_i == SNT) ? state_i : state_i - 2'd1);
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: flop-based table of 2-bit counters with resolve statistics
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS   = BP_INDEX_BITS,
  parameter logic [1:0] COUNTER_INIT = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCNow_ID,
  input  logic        IsBranch_ID,
  output logic        Prediction,
  input  logic        Resolve_EX,
  input  logic        Squash_EX,
  input  logic [31:0] PCNow_EX,
  input  logic        Taken_EX,
  input  logic        Prediction_EX,
  output logic        Mispredict,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  logic [1:0]            bht_q [ENTRIES];
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [1:0]            wr_next;
  logic                  res_valid;
  logic [31:0]           branch_cnt_q, branch_cnt_d, mis_cnt_q, mis_cnt_d;
  logic                  unused_pc;
  assign unused_pc = ^{PCNow_ID[31:INDEX_BITS+2], PCNow_ID[1:0], PCNow_EX[31:INDEX_BITS+2], PCNow_EX[1:0]};
  assign rd_idx    = PCNow_ID[INDEX_BITS+1:2];
  assign wr_idx    = PCNow_EX[INDEX_BITS+1:2];
  // rst gating keeps a resolve during reset from flagging or counting anything
  assign res_valid    = Resolve_EX & ~Squash_EX & ~rst;
  assign Prediction   = bht_q[rd_idx][1] & IsBranch_ID;
  assign Mispredict   = res_valid & (Taken_EX != Prediction_EX);
  assign branch_cnt_d = branch_cnt_q + {31'd0, ~&branch_cnt_q};
  assign mis_cnt_d    = mis_cnt_q + {31'd0, ~&mis_cnt_q};
  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mis_cnt_q;
  bht_counter_update u_upd (
    .state_i      (bht_q[wr_idx]),
    .taken_i      (Taken_EX),
    .next_state_o (wr_next)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= COUNTER_INIT;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      if (res_valid) begin
        bht_q[wr_idx] <= wr_next;
        branch_cnt_q  <= branch_cnt_d;
      end
      if (Mispredict) mis_cnt_q <= mis_cnt_d;
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed vectors with hand-computed expectations
module tb_branch_predictor_bht;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_id = '0;
  logic        is_br = 1'b0;
  logic        pred;
  logic        res = 1'b0;
  logic        squash = 1'b0;
  logic [31:0] pc_ex = '0;
  logic        taken = 1'b0;
  logic        pred_ex = 1'b0;
  logic        mis;
  logic [31:0] br_cnt, mis_cnt;
  int          n_tests = 0;
  int          n_fail = 0;

  branch_predictor_bht dut (
    .clk(clk), .rst(rst), .PCNow_ID(pc_id), .IsBranch_ID(is_br), .Prediction(pred),
    .Resolve_EX(res), .Squash_EX(squash), .PCNow_EX(pc_ex), .Taken_EX(taken),
    .Prediction_EX(pred_ex), .Mispredict(mis), .BranchCount(br_cnt), .MispredictCount(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic br);
    pc_id = pc;
    is_br = br;
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic p, input logic sq);
    res = 1'b1;
    pc_ex = pc;
    taken = t;
    pred_ex = p;
    squash = sq;
    #1;
  endtask

  task automatic idle();
    res = 1'b0;
    squash = 1'b0;
    #1;
  endtask

  initial begin
    lookup(32'h40, 1'b1);
    chk("rst_pred", pred, 0);
    resolve(32'h40, 1'b1, 1'b0, 1'b0);
    chk("rst_mis", mis, 0);
    step();
    chk("rst_brcnt", br_cnt, 0);
    chk("rst_miscnt", mis_cnt, 0);
    idle();
    rst = 1'b0;
    #1;
    chk("init_pred", pred, 0);
    lookup(32'h40, 1'b0);
    chk("nobr_pred", pred, 0);
    lookup(32'h40, 1'b1);
    resolve(32'h40, 1'b1, 1'b1, 1'b0);
    chk("t1_mis", mis, 0);
    step();
    chk("t1_pred", pred, 1);
    step();
    chk("t2_pred", pred, 1);
    step();
    idle();
    chk("t3_pred", pred, 1);
    chk("t3_brcnt", br_cnt, 3);
    chk("t3_miscnt", mis_cnt, 0);
    lookup(32'h140, 1'b1);
    chk("alias_pred", pred, 1);
    lookup(32'h43, 1'b1);
    chk("lowbits_pred", pred, 1);
    lookup(32'h44, 1'b1);
    chk("idx17_pred", pred, 0);
    lookup(32'h40, 1'b1);
    resolve(32'h40, 1'b0, 1'b1, 1'b1);
    chk("squash_mis", mis, 0);
    step();
    idle();
    chk("squash_brcnt", br_cnt, 3);
    chk("squash_miscnt", mis_cnt, 0);
    chk("squash_pred", pred, 1);
    // saturated at ST: one decrement lands on WT, still predicting taken
    resolve(32'h40, 1'b0, 1'b1, 1'b0);
    chk("dec_mis", mis, 1);
    step();
    idle();
    chk("dec_pred", pred, 1);
    chk("dec_miscnt", mis_cnt, 1);
    #2;
    rst = 1'b1;
    resolve(32'h40, 1'b0, 1'b1, 1'b0);
    chk("arst_pred", pred, 0);
    chk("arst_brcnt", br_cnt, 0);
    chk("arst_miscnt", mis_cnt, 0);
    chk("arst_mis", mis, 0);
    step();
    chk("arst_hold_brcnt", br_cnt, 0);
    chk("arst_hold_pred", pred, 0);
    idle();
    rst = 1'b0;
    #1;
    resolve(32'h40, 1'b0, 1'b1, 1'b0);
    chk("r39_mis", mis, 1);
    step();
    idle();
    chk("r39_brcnt", br_cnt, 1);
    chk("r39_miscnt", mis_cnt, 1);
    chk("r39_pred", pred, 0);
    resolve(32'h40, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    chk("sat0_brcnt", br_cnt, 2);
    resolve(32'h40, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    chk("from00_pred", pred, 0);
    resolve(32'h140, 1'b1, 1'b0, 1'b0);
    chk("bypass_pred", pred, 0);
    step();
    idle();
    chk("after_pred", pred, 1);
    chk("final_brcnt", br_cnt, 4);
    chk("final_miscnt", mis_cnt, 3);
    lookup(32'h44, 1'b1);
    chk("idx17_hold", pred, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
